kugelblitz_rewrite_engine: RTL and testbench
============================================

// Module: kugelblitz_rewrite_engine
// PURPOSE
//  Per-port AXI-Stream frame byte-rewrite engine for the kugelblitz offload path, sitting between the
//  IO MAC streams and corundum. It holds a table of RULE_COUNT rules, each {enable, offset, mask, value},
//  and rewrites each matching byte at any frame offset, across beats. Rules are loaded through a simple
//  register port. The block has full tready backpressure and one registered pipeline stage.
// PARAMETERS
//  DATA_WIDTH   512  tdata width in bits; power of two, >=64
//  KEEP_WIDTH   DATA_WIDTH/8  tkeep width; DATA_WIDTH must equal KEEP_WIDTH*8 (checked at elaboration)
//  USER_WIDTH   81   tuser width; passed through unchanged
//  RULE_COUNT   8    number of rewrite rules, 1..32
//  OFFSET_WIDTH 16   width of a rule's frame byte offset
//  CFG_ADDR_WIDTH 8  width of the config word address
// PORTS
//  clk            in   1               clock, all logic
//  rst_n          in   1               asynchronous active-low reset
//  s_axis_tdata   in   DATA_WIDTH      input frame data
//  s_axis_tkeep   in   KEEP_WIDTH      input byte enables
//  s_axis_tvalid  in   1               input valid
//  s_axis_tready  out  1               input ready
//  s_axis_tlast   in   1               end of frame
//  s_axis_tuser   in   USER_WIDTH      sideband, forwarded
//  m_axis_tdata   out  DATA_WIDTH      rewritten data
//  m_axis_tkeep   out  KEEP_WIDTH      forwarded tkeep
//  m_axis_tvalid  out  1               output valid
//  m_axis_tready  in   1               output ready
//  m_axis_tlast   out  1               forwarded tlast
//  m_axis_tuser   out  USER_WIDTH      forwarded tuser
//  cfg_wr_en      in   1               one-cycle config write strobe
//  cfg_rd_en      in   1               one-cycle config read strobe
//  cfg_addr       in   CFG_ADDR_WIDTH  config word address
//  cfg_wdata      in   32              write data
//  cfg_rdata      out  32              read data, valid while cfg_rd_valid is high
//  cfg_rd_valid   out  1               pulses one cycle after cfg_rd_en
// BEHAVIOUR
//  - Reset (rst_n low, async assert, sync deassert): m_axis_tvalid=0, the m_axis_* data regs=0,
//    cfg_rdata=0, cfg_rd_valid=0, all rules disabled (staging and active tables), beat_idx=0,
//    FSM=IDLE. s_axis_tready=1 after reset.
//  - Handshake: output register slice. s_axis_tready = !m_axis_tvalid || m_axis_tready.
//    A beat is accepted when s_axis_tvalid && s_axis_tready. Latency is 1 cycle. A full-throughput
//    stream has no bubbles. Output holds stable while m_axis_tvalid && !m_axis_tready.
//  - Cfg map: rule r word 2r = {en[31], offset[OFFSET_WIDTH-1:0]}; word 2r+1 = {mask[15:8], value[7:0]};
//    word 0x80 = CTRL {commit[0]} (write-only, reads 0). Writes go to the staging table.
//    Unmapped reads return 0; unmapped writes are ignored.
//  - The active table is the one used for matching. It is loaded from staging on a commit when
//    FSM=IDLE; a commit in IN_FRAME is held pending until the FSM next enters IDLE. This keeps each
//    frame rewritten by one consistent table.
//  - FSM: IDLE -(accept, !tlast)-> IN_FRAME; IN_FRAME -(accept, tlast)-> IDLE.
//    A single-beat frame (accept with tlast in IDLE) stays in IDLE.
//  - beat_idx: 0 on the first beat of a frame, +1 per accepted non-last beat. It saturates at
//    all-ones, and offsets beyond that never match. It clears on an accepted tlast.
//  - Match: byte b of a beat matches rule r when en_r && offset_r[OFFSET_WIDTH-1:log2(KEEP_WIDTH)]==beat_idx
//    && offset_r[log2(KEEP_WIDTH)-1:0]==b && tkeep[b].
//  - Merge: out = (in & ~mask) | (value & mask). If several rules hit the same byte, the
//    highest-index rule wins (no accumulation).
//  - Bytes with tkeep[b]=0 are driven 8'h00 on m_axis_tdata. tkeep, tlast and tuser pass unchanged.
//  - Simultaneous cfg_wr_en and cfg_rd_en to the same address: the read returns the old value.
//  - Reset mid-frame: the output beat is dropped and the FSM returns to IDLE. Upstream must restart
//    the frame.
// CONFIGURATION
//  KG_REWRITE_STATS_EN defined: 32-bit wrapping counters at cfg 0x81 frames_total (+1 per accepted
//    tlast) and 0x82 frames_hit (+1 per frame with >=1 rewritten byte). Writing any value to 0x81
//    clears both counters. Reset value 0.
//  KG_REWRITE_STATS_EN undefined: no counters exist, and 0x81/0x82 read 0 and ignore writes.
// STRUCTURE
//  - Package kugelblitz_rewrite_pkg: rule struct {en, offset, mask, value}, the cfg address
//    constants (RULE_BASE, CTRL=0x80, STAT_TOTAL=0x81, STAT_HIT=0x82), and a LANE_BITS function.
//  - Sub-module kugelblitz_rewrite_lane: per-byte-lane combinational match and priority merge over
//    the active table. It is instantiated KEEP_WIDTH times with a lane-index parameter.
// TESTING
//  1 Rule0 {en, off=5, mask=FF, val=AA}, commit, send a 64B single-beat frame of 0x00..0x3F -> byte5=AA,
//    others unchanged, 1-cycle latency.
//  2 Rule1 off=70, mask=0F, val=03, 2-beat frame with in byte 70 (beat1 lane6)=0x5C -> out 0x53;
//    beat0 untouched.
//  3 Rules 2,3 both off=9 (vals 11, 22) -> byte9=22. Disable rule3 and commit -> byte9=11.
//  4 Commit rule change mid-frame -> current frame uses old table; next frame uses new.
//  5 Random tvalid/tready 50% toggling, 1000 frames -> no loss/duplication, output stable under stall.
//  6 KG_REWRITE_STATS_EN: 10 frames with 4 hits -> 0x81=10, 0x82=4; write 0x81 -> both 0.
//    Without the macro, both read 0.

Source files
------------

// File: rtl/kugelblitz_rewrite_pkg.sv
// Shared types and constants for the kugelblitz rewrite engine: rule record,
// config word addresses and the lane-index width helper.
package kugelblitz_rewrite_pkg;

   // Offsets are kept zero-extended to 31 bits so the lane compare can use the whole field.
   typedef struct packed {
      logic        en;
      logic [30:0] offset;
      logic [7:0]  mask;
      logic [7:0]  value;
   } rule_t;

   localparam logic [31:0] CFG_RULE_BASE  = 32'h0000_0000;
   localparam logic [31:0] CFG_CTRL       = 32'h0000_0080;
   localparam logic [31:0] CFG_STAT_TOTAL = 32'h0000_0081;
   localparam logic [31:0] CFG_STAT_HIT   = 32'h0000_0082;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } state_t;

   // Number of low offset bits that select a byte lane within one beat.
   function automatic int lane_bits(input int keep_width);
      return $clog2(keep_width);
   endfunction

endpackage

// File: rtl/kugelblitz_rewrite_lane.sv
// One byte lane: match every active rule against this lane's frame position
// and merge the highest-index hit into the byte. Lanes without tkeep read 0.
module kugelblitz_rewrite_lane
   import kugelblitz_rewrite_pkg::*;
#(
   parameter int RULE_COUNT   = 8,
   parameter int OFFSET_WIDTH = 16,
   parameter int LANE_BITS    = 6,
   parameter int LANE         = 0
) (
   input  rule_t                             rules [RULE_COUNT],
   input  logic [OFFSET_WIDTH-LANE_BITS-1:0] beat_idx,
   input  logic                              beat_ovf,
   input  logic                              keep,
   input  logic [7:0]                        din,
   output logic [7:0]                        dout,
   output logic                              hit
);

   localparam logic [LANE_BITS-1:0] LANE_V = LANE_BITS'(LANE);

   // Frame byte position of this lane in the current beat.
   logic [30:0] pos;
   assign pos = 31'({beat_idx, LANE_V});

   logic [7:0] mask_sel;
   logic [7:0] value_sel;

   // Scan rules low to high so the highest-index hit overrides earlier ones.
   always_comb begin
      mask_sel  = 8'h00;
      value_sel = 8'h00;
      hit       = 1'b0;
      for (int r = 0; r < RULE_COUNT; r++) begin
         if (rules[r].en && !beat_ovf && keep && (rules[r].offset == pos)) begin
            hit       = 1'b1;
            mask_sel  = rules[r].mask;
            value_sel = rules[r].value;
         end
      end
      dout = keep ? ((din & ~mask_sel) | (value_sel & mask_sel)) : 8'h00;
   end

endmodule

// File: rtl/kugelblitz_rewrite_engine.sv
// AXI-Stream frame byte-rewrite engine with one output register slice.
// Optional frame statistics are enabled with the KG_REWRITE_STATS_EN macro.
// Valid/ready: a beat moves on a port when tvalid && tready in the same cycle;
// s_axis_tready = !m_axis_tvalid || m_axis_tready, and a stalled output holds.
module kugelblitz_rewrite_engine
   import kugelblitz_rewrite_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int USER_WIDTH     = 81,
   parameter int RULE_COUNT     = 8,
   parameter int OFFSET_WIDTH   = 16,
   parameter int CFG_ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   input  logic [USER_WIDTH-1:0]     s_axis_tuser,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [USER_WIDTH-1:0]     m_axis_tuser,
   input  logic                      cfg_wr_en,
   input  logic                      cfg_rd_en,
   input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
   input  logic [31:0]               cfg_wdata,
   output logic [31:0]               cfg_rdata,
   output logic                      cfg_rd_valid
);

   localparam int LB = lane_bits(KEEP_WIDTH);
   localparam int BW = OFFSET_WIDTH - LB;

   if (DATA_WIDTH != KEEP_WIDTH * 8) begin : g_bad_width
      $error("kugelblitz_rewrite_engine: DATA_WIDTH must equal KEEP_WIDTH*8");
   end

   rule_t             stage_q  [RULE_COUNT];
   rule_t             active_q [RULE_COUNT];
   state_t            state_q, state_d;
   logic [BW-1:0]     beat_idx_q;
   logic              beat_ovf_q;
   logic              commit_pending_q;
   logic              s_fire;
   logic              commit_wr;
   logic              load_active;
   logic [31:0]       addr32;
   logic [31:0]       rd_mux;
   logic [DATA_WIDTH-1:0] rew_data;
   logic [KEEP_WIDTH-1:0] lane_hit;
   logic              unused_wdata;

`ifdef KG_REWRITE_STATS_EN
   logic [31:0] frames_total_q;
   logic [31:0] frames_hit_q;
   logic        frame_hit_q;
`else
   logic        unused_hit;
   assign unused_hit = ^lane_hit;
`endif

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign addr32        = 32'(cfg_addr);
   assign commit_wr     = cfg_wr_en && (addr32 == CFG_CTRL) && cfg_wdata[0];
   // Swap tables only at a frame boundary so a frame never mixes two tables.
   assign load_active   = (commit_pending_q || commit_wr) && (state_d == IDLE);
   assign unused_wdata  = ^cfg_wdata;

   for (genvar b = 0; b < KEEP_WIDTH; b++) begin : g_lane
      kugelblitz_rewrite_lane #(
         .RULE_COUNT  (RULE_COUNT),
         .OFFSET_WIDTH(OFFSET_WIDTH),
         .LANE_BITS   (LB),
         .LANE        (b)
      ) u_lane (
         .rules   (active_q),
         .beat_idx(beat_idx_q),
         .beat_ovf(beat_ovf_q),
         .keep    (s_axis_tkeep[b]),
         .din     (s_axis_tdata[b*8 +: 8]),
         .dout    (rew_data[b*8 +: 8]),
         .hit     (lane_hit[b])
      );
   end

   // Frame-boundary FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (s_fire && !s_axis_tlast) state_d = IN_FRAME;
         IN_FRAME: if (s_fire && s_axis_tlast)  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State register and saturating beat index within the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         beat_idx_q <= '0;
         beat_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (s_fire) begin
            if (s_axis_tlast) begin
               beat_idx_q <= '0;
               beat_ovf_q <= 1'b0;
            end else if (&beat_idx_q) begin
               beat_ovf_q <= 1'b1;
            end else begin
               beat_idx_q <= beat_idx_q + 1'b1;
            end
         end
      end
   end

   // Output register slice; loads whenever the slot is free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else if (s_axis_tready) begin
         m_axis_tvalid <= s_axis_tvalid;
         if (s_axis_tvalid) begin
            m_axis_tdata <= rew_data;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tlast <= s_axis_tlast;
            m_axis_tuser <= s_axis_tuser;
         end
      end
   end

   // Staging writes, pending commit and staging-to-active copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < RULE_COUNT; r++) begin
            stage_q[r]  <= '0;
            active_q[r] <= '0;
         end
         commit_pending_q <= 1'b0;
      end else begin
         if (cfg_wr_en) begin
            for (int r = 0; r < RULE_COUNT; r++) begin
               if (addr32 == CFG_RULE_BASE + 32'(2 * r)) begin
                  stage_q[r].en     <= cfg_wdata[31];
                  stage_q[r].offset <= 31'(cfg_wdata[OFFSET_WIDTH-1:0]);
               end else if (addr32 == CFG_RULE_BASE + 32'(2 * r + 1)) begin
                  stage_q[r].mask  <= cfg_wdata[15:8];
                  stage_q[r].value <= cfg_wdata[7:0];
               end
            end
         end
         if (load_active) begin
            active_q         <= stage_q;
            commit_pending_q <= 1'b0;
         end else if (commit_wr) begin
            commit_pending_q <= 1'b1;
         end
      end
   end

   // Config read mux over the staging table and counters; CTRL reads 0.
   always_comb begin
      rd_mux = 32'h0;
      for (int r = 0; r < RULE_COUNT; r++) begin
         if (addr32 == CFG_RULE_BASE + 32'(2 * r))
            rd_mux = {stage_q[r].en, stage_q[r].offset};
         else if (addr32 == CFG_RULE_BASE + 32'(2 * r + 1))
            rd_mux = {16'h0, stage_q[r].mask, stage_q[r].value};
      end
`ifdef KG_REWRITE_STATS_EN
      if (addr32 == CFG_STAT_TOTAL) rd_mux = frames_total_q;
      if (addr32 == CFG_STAT_HIT)   rd_mux = frames_hit_q;
`endif
   end

   // Registered read response, one cycle after the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_rdata    <= 32'h0;
         cfg_rd_valid <= 1'b0;
      end else begin
         cfg_rd_valid <= cfg_rd_en;
         cfg_rdata    <= cfg_rd_en ? rd_mux : 32'h0;
      end
   end

`ifdef KG_REWRITE_STATS_EN
   // Frame counters; a write to the total address clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_total_q <= 32'h0;
         frames_hit_q   <= 32'h0;
         frame_hit_q    <= 1'b0;
      end else begin
         if (s_fire) begin
            if (s_axis_tlast) begin
               frames_total_q <= frames_total_q + 32'h1;
               if (frame_hit_q || (|lane_hit)) frames_hit_q <= frames_hit_q + 32'h1;
               frame_hit_q <= 1'b0;
            end else begin
               frame_hit_q <= frame_hit_q || (|lane_hit);
            end
         end
         if (cfg_wr_en && (addr32 == CFG_STAT_TOTAL)) begin
            frames_total_q <= 32'h0;
            frames_hit_q   <= 32'h0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_kugelblitz_rewrite_engine.sv
// Scoreboard bench for kugelblitz_rewrite_engine: expected beats are queued on
// input acceptance from a byte-position model and compared on output transfer.
module tb_kugelblitz_rewrite_engine;

   localparam int DW   = 512;
   localparam int KW   = 64;
   localparam int UW   = 81;
   localparam int NR   = 8;
   localparam int SB_W = DW + KW + 1 + UW;

   typedef struct {
      bit         en;
      int         off;
      logic [7:0] mask;
      logic [7:0] val;
   } mrule_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [KW-1:0] s_tkeep = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [UW-1:0] s_tuser = '0;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic [UW-1:0] m_tuser;
   logic          cfg_wr_en = 1'b0;
   logic          cfg_rd_en = 1'b0;
   logic [7:0]    cfg_addr = '0;
   logic [31:0]   cfg_wdata = '0;
   logic [31:0]   cfg_rdata;
   logic          cfg_rd_valid;

   int checks = 0;
   int errors = 0;
   logic [SB_W-1:0] exp_q[$];
   mrule_t m_stage [NR];
   mrule_t m_active [NR];
   bit     m_pending = 0;
   bit     m_in_frame = 0;
   int     m_beat = 0;
   bit     rand_mode = 0;
   int     cyc = 0;
   int     acc_cyc = 0;
   int     out_cyc = 0;
   logic [DW-1:0]   last_out = '0;
   logic [SB_W-1:0] prev_out = '0;
   bit     prev_stall = 0;

   kugelblitz_rewrite_engine dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [SB_W-1:0] got, input logic [SB_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: rewrite by absolute frame byte position.
   function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                                input int beat);
      logic [DW-1:0] o;
      logic [7:0] mk, vl;
      o = '0;
      for (int b = 0; b < KW; b++) begin
         mk = 8'h00;
         vl = 8'h00;
         for (int r = 0; r < NR; r++)
            if (m_active[r].en && (m_active[r].off == beat * KW + b)) begin
               mk = m_active[r].mask;
               vl = m_active[r].val;
            end
         o[b*8 +: 8] = k[b] ? ((d[b*8 +: 8] & ~mk) | (vl & mk)) : 8'h00;
      end
      return o;
   endfunction

   function automatic logic [DW-1:0] pat_beat(input int i);
      logic [DW-1:0] d;
      for (int b = 0; b < KW; b++) d[b*8 +: 8] = 8'(i * KW + b);
      return d;
   endfunction

   // output-side random backpressure
   always @(negedge clk) m_tready <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;

   // monitor: sampled 1 time unit after the falling edge, stable up to the next rising edge
   always @(negedge clk) begin
      #1;
      cyc++;
      if (rst_n) begin
         if (prev_stall) check("stall_hold", {m_tdata, m_tkeep, m_tlast, m_tuser}, prev_out);
         prev_stall = m_tvalid && !m_tready;
         prev_out   = {m_tdata, m_tkeep, m_tlast, m_tuser};
         if (m_tvalid && m_tready) begin
            out_cyc  = cyc;
            last_out = m_tdata;
            if (exp_q.size() == 0) check("out_unexpected", 1, 0);
            else check("out_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, exp_q.pop_front());
         end
         if (s_tvalid && s_tready) begin
            acc_cyc = cyc;
            exp_q.push_back({model_beat(s_tdata, s_tkeep, m_beat), s_tkeep, s_tlast, s_tuser});
            if (s_tlast) begin
               m_beat     = 0;
               m_in_frame = 0;
               if (m_pending) begin
                  m_active  = m_stage;
                  m_pending = 0;
               end
            end else begin
               m_beat++;
               m_in_frame = 1;
            end
         end
      end
   end

   // driver tasks (entered at a falling edge, leave at a falling edge)
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last,
                            input logic [UW-1:0] u);
      bit done = 0;
      if (rand_mode) while ($urandom_range(0, 1) == 1) @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = last;
      s_tuser  = u;
      for (int t = 0; t < 2000 && !done; t++) begin
         #1;
         done = s_tready;
         @(negedge clk);
      end
      if (!done) check("send_timeout", 0, 1);
      s_tvalid = 1'b0;
   endtask

   task automatic send_pat_frame(input int nbeats);
      for (int i = 0; i < nbeats; i++)
         send_beat(pat_beat(i), '1, i == nbeats - 1, UW'(i + 7));
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic cfg_write(input int addr, input logic [31:0] d);
      if (addr < 2 * NR) begin
         if (addr % 2 == 0) begin
            m_stage[addr/2].en  = d[31];
            m_stage[addr/2].off = int'(d[15:0]);
         end else begin
            m_stage[addr/2].mask = d[15:8];
            m_stage[addr/2].val  = d[7:0];
         end
      end
      if (addr == 'h80 && d[0]) begin
         if (m_in_frame) m_pending = 1;
         else m_active = m_stage;
      end
      cfg_wr_en = 1'b1;
      cfg_addr  = 8'(addr);
      cfg_wdata = d;
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic cfg_read_check(input string tag, input int addr, input logic [31:0] exp);
      cfg_rd_en = 1'b1;
      cfg_addr  = 8'(addr);
      @(negedge clk);
      cfg_rd_en = 1'b0;
      #1;
      check({tag, "_vld"}, cfg_rd_valid, 1);
      check(tag, cfg_rdata, exp);
      @(negedge clk);
   endtask

   task automatic set_rule(input int r, input bit en, input int off, input logic [7:0] mask,
                           input logic [7:0] val);
      cfg_write(2 * r, {en, 15'h0, 16'(off)});
      cfg_write(2 * r + 1, {16'h0, mask, val});
   endtask

   task automatic commit();
      cfg_write('h80, 32'h1);
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      int nb;
      for (int r = 0; r < NR; r++) m_stage[r] = '{0, 0, 8'h00, 8'h00};
      m_active = m_stage;

      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_s_tready", s_tready, 1);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_cfg_rdata", cfg_rdata, 0);
      check("rst_rd_valid", cfg_rd_valid, 0);
      @(negedge clk);

      // 1: single rule, single-beat frame, latency
      set_rule(0, 1, 5, 8'hFF, 8'hAA);
      cfg_read_check("rd_rule0_w0", 0, 32'h8000_0005);
      cfg_read_check("rd_rule0_w1", 1, 32'h0000_FFAA);
      cfg_read_check("rd_ctrl", 'h80, 32'h0);
      cfg_read_check("rd_unmapped", 'h40, 32'h0);
      commit();
      send_pat_frame(1);
      drain();
      check("t1_byte5", last_out[5*8 +: 8], 8'hAA);
      check("t1_byte6", last_out[6*8 +: 8], 8'h06);
      check("t1_latency", out_cyc - acc_cyc, 1);

      // simultaneous write and read of one word returns the old value
      cfg_wr_en = 1'b1; cfg_rd_en = 1'b1; cfg_addr = 8'h01; cfg_wdata = 32'h0000_1234;
      m_stage[0].mask = 8'h12; m_stage[0].val = 8'h34;
      @(negedge clk);
      cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
      #1;
      check("rd_wr_same_old", cfg_rdata, 32'h0000_FFAA);
      @(negedge clk);
      cfg_read_check("rd_wr_same_new", 1, 32'h0000_1234);

      // 2: nibble merge in the second beat, masked-off lane reads zero
      set_rule(0, 0, 5, 8'hFF, 8'hAA);
      set_rule(1, 1, 70, 8'h0F, 8'h03);
      commit();
      send_beat(pat_beat(0), '1, 0, UW'(1));
      d = pat_beat(1);
      d[6*8 +: 8] = 8'h5C;
      k = '1;
      k[7] = 1'b0;
      send_beat(d, k, 1, UW'(2));
      drain();
      check("t2_byte70", last_out[6*8 +: 8], 8'h53);
      check("t2_nokeep", last_out[7*8 +: 8], 8'h00);

      // 3: highest-index rule wins on a shared byte
      set_rule(2, 1, 9, 8'hFF, 8'h11);
      set_rule(3, 1, 9, 8'hFF, 8'h22);
      commit();
      send_pat_frame(1);
      drain();
      check("t3_prio", last_out[9*8 +: 8], 8'h22);
      set_rule(3, 0, 9, 8'hFF, 8'h22);
      commit();
      send_pat_frame(1);
      drain();
      check("t3_lower", last_out[9*8 +: 8], 8'h11);

      // 4: commit inside a frame only takes effect on the next frame
      set_rule(2, 1, 73, 8'hFF, 8'h11);
      commit();
      send_beat(pat_beat(0), '1, 0, UW'(3));
      set_rule(2, 1, 73, 8'hFF, 8'h77);
      commit();
      send_beat(pat_beat(1), '1, 1, UW'(4));
      drain();
      check("t4_old_table", last_out[9*8 +: 8], 8'h11);
      send_pat_frame(2);
      drain();
      check("t4_new_table", last_out[9*8 +: 8], 8'h77);

      // beat index saturation: last reachable offset hits, the beat after it does not
      set_rule(4, 1, 65535, 8'hFF, 8'hEE);
      commit();
      send_pat_frame(1025);
      drain();
      check("sat_no_match", last_out[63*8 +: 8], 8'h3F);
      set_rule(4, 0, 65535, 8'hFF, 8'hEE);
      set_rule(5, 1, $urandom_range(0, 191), 8'($urandom), 8'($urandom));
      commit();

      // 5: random valid/ready, 1000 frames
      rand_mode = 1;
      for (int f = 0; f < 1000; f++) begin
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb; i++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
            k = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : '1;
            send_beat(d, k, i == nb - 1, {17'($urandom), $urandom, $urandom});
         end
      end
      rand_mode = 0;
      drain();

      // 6: statistics
      for (int r = 1; r < NR; r++) set_rule(r, 0, 0, 8'h00, 8'h00);
      set_rule(0, 1, 5, 8'hFF, 8'hAA);
      commit();
      cfg_write('h81, 32'h0);
      for (int f = 0; f < 10; f++) begin
         k = '1;
         if (f >= 4) k[5] = 1'b0;
         send_beat(pat_beat(0), k, 1, UW'(f));
      end
      drain();
`ifdef KG_REWRITE_STATS_EN
      cfg_read_check("stat_total", 'h81, 32'd10);
      cfg_read_check("stat_hit", 'h82, 32'd4);
`else
      cfg_read_check("stat_total", 'h81, 32'd0);
      cfg_read_check("stat_hit", 'h82, 32'd0);
`endif
      cfg_write('h81, 32'h5);
      cfg_read_check("stat_total_clr", 'h81, 32'd0);
      cfg_read_check("stat_hit_clr", 'h82, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
